// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read-port register file with hardware clear sweep.
//            Optional write-first bypass is enabled by `REGFILE_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_req_i,
  output logic                     init_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [N_RD-1:0]          rd_en_i,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [N_RD*DATA_W-1:0]   rd_data_o,
  output logic [N_RD-1:0]          rd_valid_o
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [NREGS];
  logic                w_run;
  logic                w_wr_fire;

  assign w_run       = (state_q == S_RUN);
  assign init_busy_o = ~w_run;
  // A sweep request in the same cycle wins over the write.
  assign w_wr_fire   = w_run && wr_en_i && !init_req_i &&
                       !((ZERO_REG != 0) && (wr_addr_i == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (init_req_i) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset; the sweep guarantees every entry is defined before use.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      mem_q[cnt_q] <= '0;
    end else if (w_wr_fire) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_arr;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    assign w_addr = rd_addr_i[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign w_arr = (w_wr_fire && (wr_addr_i == w_addr)) ? wr_data_i : mem_q[w_addr];
`else
    assign w_arr = mem_q[w_addr];
`endif

    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (w_run && rd_en_i[i]) begin
        rd_valid_d = 1'b1;
        rd_data_d  = ((ZERO_REG != 0) && (w_addr == '0)) ? '0 : w_arr;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data_o[i*DATA_W +: DATA_W] = rd_data_q;
    assign rd_valid_o[i]                 = rd_valid_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Randomised scoreboard bench for regfile_mp against an array model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 2;
  localparam int NREGS  = 32;
  localparam bit ZR     = 1'b1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP    = 1'b1;
`else
  localparam bit BYP    = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   init_req = 1'b0;
  logic                   init_busy;
  logic                   wr_en = 1'b0;
  logic [ADDR_W-1:0]      wr_addr = '0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic [N_RD-1:0]        rd_en = '0;
  logic [N_RD*ADDR_W-1:0] rd_addr = '0;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_valid;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_req_i (init_req),
    .init_busy_o(init_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [NREGS];
  int          busy_left = NREGS;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: busy flag every cycle, read responses popped whenever valid.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("init_busy", {31'd0, init_busy}, {31'd0, (busy_left > 0)});
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_valid port %0d: got no response, required %h at cyc %0d",
                 sb[0].port, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      for (int p = 0; p < N_RD; p++) begin
        if (rd_valid[p]) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid port %0d @cyc %0d: got data %h, required no valid",
                     p, cyc, rd_data[p*DATA_W +: DATA_W]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_port", p, e.port);
            chk("rd_cycle", cyc, e.due);
            chk("rd_data", rd_data[p*DATA_W +: DATA_W], e.data);
          end
        end
      end
    end
  end

  // One clock of stimulus; the model follows the behavioural rules directly.
  task automatic cycle(input bit ir, input bit we, input int wa, input logic [31:0] wd,
                       input logic [1:0] re, input int ra0, input int ra1);
    bit          we_eff;
    int          a;
    logic [31:0] e;
    init_req = ir;
    wr_en    = we;
    wr_addr  = wa[4:0];
    wr_data  = wd;
    rd_en    = re;
    rd_addr  = {ra1[4:0], ra0[4:0]};
    we_eff   = (busy_left == 0) && we && !ir && !(ZR && wa == 0);
    if (busy_left == 0) begin
      for (int p = 0; p < N_RD; p++) begin
        if (re[p]) begin
          a = (p == 0) ? ra0 : ra1;
          if (ZR && a == 0)                 e = 32'd0;
          else if (BYP && we_eff && wa == a) e = wd;
          else                               e = ref_mem[a];
          sb.push_back('{cyc + 1, p, e});
        end
      end
    end
    @(posedge clk);
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) foreach (ref_mem[k]) ref_mem[k] = 32'd0;
    end else begin
      if (we_eff) ref_mem[wa] = wd;
      if (ir) busy_left = NREGS;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 32'd0, 2'b00, 0, 0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cycle(0, 1, a, d, 2'b00, 0, 0);
  endtask

  task automatic rd2(input int a0, input int a1);
    cycle(0, 0, 0, 32'd0, 2'b11, a0, a1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (ref_mem[k]) ref_mem[k] = 32'd0;
    #1;
    chk("reset_valid", {30'd0, rd_valid}, 32'd0);
    chk("reset_data0", rd_data[31:0], 32'd0);
    chk("reset_data1", rd_data[63:32], 32'd0);
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst       = 1'b0;
    busy_left = NREGS;
    mon_en    = 1'b1;

    // T1: sweep after reset, then all registers read zero
    idle(NREGS);
    idle(1);
    for (int r = 0; r < NREGS; r++) rd2(r, NREGS - 1 - r);

    // T2: write then dual read
    wr(5, 32'hDEADBEEF);
    rd2(5, 5);

    // T3: register 0 ignores writes
    wr(0, 32'h12345678);
    rd2(0, 0);

    // T4: same-cycle write and read
    wr(9, 32'h1);
    cycle(0, 1, 9, 32'hA5A5A5A5, 2'b11, 9, 9);
    rd2(9, 9);

    // T5: fill, clear request, traffic during sweep, then verify zeros
    for (int r = 1; r < NREGS; r++) wr(r, 32'hFF);
    rd2(17, 31);
    cycle(1, 0, 0, 32'd0, 2'b00, 0, 0);
    cycle(0, 1, 7, 32'h77, 2'b11, 7, 7);
    idle(10);
    cycle(0, 1, 12, 32'hABCD, 2'b01, 12, 0);
    idle(NREGS);
    for (int r = 0; r < NREGS; r++) rd2(r, r);

    // Randomised traffic, rare clear requests
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 31), $urandom_range(0, 31));
    end
    idle(NREGS + 2);

    // T6: async reset at sweep cycle 10
    wr(3, 32'hCAFEF00D);
    rd2(3, 3);
    cycle(1, 0, 0, 32'd0, 2'b00, 0, 0);
    idle(10);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", {30'd0, rd_valid}, 32'd0);
    chk("t6_data0", rd_data[31:0], 32'd0);
    chk("t6_data1", rd_data[63:32], 32'd0);
    chk("t6_busy", {31'd0, init_busy}, 32'd1);
    sb.delete();
    busy_left = NREGS;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(NREGS);
    for (int r = 0; r < NREGS; r += 3) rd2(r, r + 1);
    idle(3);

    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
